// File: rtl/store_check_monitor.sv
// store_check_monitor
//   Snoops the data-memory write port (MemWrite/DataAdr/WriteData) and checks
//   the stores against an ordered table of expected (address, data) pairs.
//   Stores to up to NUM_IGN scratch addresses are tolerated. A run resolves
//   to PASS once every expected store has been seen in order. It resolves to
//   FAIL on a data mismatch, on an unexpected address, or on a cycle timeout.
//   For the first two failure kinds the offending store is captured.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (control/status only)
//   start      begin a run from IDLE/PASS/FAIL (ignored while running)
//   ld_we      expected-table write enable (ignored while running)
//   ld_idx     expected-table entry index
//   ld_adr     expected store address for the entry
//   ld_data    expected store data for the entry
//   exp_len    number of entries to check, sampled on start, clamped to DEPTH
//   ign_adr    NUM_IGN packed scratch addresses; entry i at [i*AW +: AW]
//   MemWrite   snooped store strobe
//   DataAdr    snooped store address
//   WriteData  snooped store data
//   busy       run in progress
//   done       run finished (PASS or FAIL)
//   pass       run finished successfully
//   fail_code  00 none, 01 data mismatch, 10 unexpected address, 11 timeout
//   match_idx  number of expected stores matched so far
//   cycles     clock edges spent running, saturating
//   err_adr    captured offending store address
//   err_data   captured offending store data
module store_check_monitor #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DEPTH   = 8,
  parameter int NUM_IGN = 2,
  parameter int TIMEOUT = 1000,
  parameter int CW      = 16,
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  ld_we,
  input  logic [IW-1:0]         ld_idx,
  input  logic [AW-1:0]         ld_adr,
  input  logic [DW-1:0]         ld_data,
  input  logic [LW-1:0]         exp_len,
  input  logic [NUM_IGN*AW-1:0] ign_adr,
  input  logic                  MemWrite,
  input  logic [AW-1:0]         DataAdr,
  input  logic [DW-1:0]         WriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code,
  output logic [LW-1:0]         match_idx,
  output logic [CW-1:0]         cycles,
  output logic [AW-1:0]         err_adr,
  output logic [DW-1:0]         err_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_DATA = 2'b01;
  localparam logic [1:0] CODE_ADR  = 2'b10;
  localparam logic [1:0] CODE_TMO  = 2'b11;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  // Last cycle count before the timeout edge; unused when TIMEOUT is 0.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  // Expected-store table and latched length deliberately have no reset so a
  // loaded program check survives a reset pulse.
  logic [AW-1:0] r_tbl_adr  [DEPTH];
  logic [DW-1:0] r_tbl_data [DEPTH];
  logic [LW-1:0] r_len;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [1:0]    r_code;
  logic [LW-1:0] r_match;
  logic [CW-1:0] r_cycles;
  logic [AW-1:0] r_err_adr;
  logic [DW-1:0] r_err_data;

  state_t        w_state_nxt;
  logic [1:0]    w_code_nxt;
  logic [LW-1:0] w_match_nxt;
  logic [CW-1:0] w_cycles_nxt;
  logic [AW-1:0] w_err_adr_nxt;
  logic [DW-1:0] w_err_data_nxt;

  logic          w_start_ok;
  logic [LW-1:0] w_len_start;
  logic [LW-1:0] w_match_inc;
  logic [AW-1:0] w_exp_adr;
  logic [DW-1:0] w_exp_data;
  logic          w_adr_hit;
  logic          w_data_hit;
  logic          w_ign_hit;
  logic          w_to_hit;

  assign w_start_ok  = start && (r_state != S_RUN);
  assign w_len_start = (exp_len > DEPTH_L) ? DEPTH_L : exp_len;
  assign w_match_inc = r_match + 1'b1;

  // In RUN match_idx < len <= DEPTH, so the low bits always address a valid entry.
  assign w_exp_adr  = r_tbl_adr[r_match[IW-1:0]];
  assign w_exp_data = r_tbl_data[r_match[IW-1:0]];
  assign w_adr_hit  = (DataAdr == w_exp_adr);
  assign w_data_hit = (WriteData == w_exp_data);
  assign w_to_hit   = (TIMEOUT != 0) && (r_cycles == TO_LAST);

  always_comb begin
    w_ign_hit = 1'b0;
    for (int i = 0; i < NUM_IGN; i++) begin
      if (DataAdr == ign_adr[i*AW +: AW]) w_ign_hit = 1'b1;
    end
  end

  // Table and length storage
  always_ff @(posedge clk) begin
    if (ld_we && (r_state != S_RUN) && (int'(ld_idx) < DEPTH)) begin
      r_tbl_adr[ld_idx]  <= ld_adr;
      r_tbl_data[ld_idx] <= ld_data;
    end
    if (w_start_ok) r_len <= w_len_start;
  end

  // State and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_code     <= CODE_NONE;
      r_match    <= '0;
      r_cycles   <= '0;
      r_err_adr  <= '0;
      r_err_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL);
      r_pass     <= (w_state_nxt == S_PASS);
      r_code     <= w_code_nxt;
      r_match    <= w_match_nxt;
      r_cycles   <= w_cycles_nxt;
      r_err_adr  <= w_err_adr_nxt;
      r_err_data <= w_err_data_nxt;
    end
  end

  // Next-state and next-status decode
  always_comb begin
    logic resolved;
    resolved       = 1'b0;
    w_state_nxt    = r_state;
    w_code_nxt     = r_code;
    w_match_nxt    = r_match;
    w_cycles_nxt   = r_cycles;
    w_err_adr_nxt  = r_err_adr;
    w_err_data_nxt = r_err_data;

    case (r_state)
      S_RUN: begin
        w_cycles_nxt = (&r_cycles) ? r_cycles : r_cycles + 1'b1;
        if (MemWrite) begin
          // Expected address wins over the ignore list.
          if (w_adr_hit && w_data_hit) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == r_len) begin
              w_state_nxt = S_PASS;
              resolved    = 1'b1;
            end
          end else if (w_adr_hit) begin
            w_state_nxt    = S_FAIL;
            w_code_nxt     = CODE_DATA;
            w_err_adr_nxt  = DataAdr;
            w_err_data_nxt = WriteData;
            resolved       = 1'b1;
          end else if (!w_ign_hit) begin
            w_state_nxt    = S_FAIL;
            w_code_nxt     = CODE_ADR;
            w_err_adr_nxt  = DataAdr;
            w_err_data_nxt = WriteData;
            resolved       = 1'b1;
          end
        end
        // A store resolving on the same edge takes precedence over timeout.
        if (!resolved && w_to_hit) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = CODE_TMO;
        end
      end
      default: begin
        if (start) begin
          w_code_nxt     = CODE_NONE;
          w_match_nxt    = '0;
          w_cycles_nxt   = '0;
          w_err_adr_nxt  = '0;
          w_err_data_nxt = '0;
          w_state_nxt    = (w_len_start == '0) ? S_PASS : S_RUN;
        end
      end
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_code = r_code;
  assign match_idx = r_match;
  assign cycles    = r_cycles;
  assign err_adr   = r_err_adr;
  assign err_data  = r_err_data;

endmodule

// File: tb/tb_store_check_monitor.sv
// Directed testbench for store_check_monitor (TIMEOUT = 20, DEPTH = 8).
module tb_store_check_monitor;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int NUM_IGN = 2;
  localparam int TIMEOUT = 20;
  localparam int CW = 16;
  localparam int IW = 3;
  localparam int LW = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic                  ld_we = 1'b0;
  logic [IW-1:0]         ld_idx = '0;
  logic [AW-1:0]         ld_adr = '0;
  logic [DW-1:0]         ld_data = '0;
  logic [LW-1:0]         exp_len = '0;
  logic [NUM_IGN*AW-1:0] ign_adr = {32'd96, 32'd96};
  logic                  MemWrite = 1'b0;
  logic [AW-1:0]         DataAdr = '0;
  logic [DW-1:0]         WriteData = '0;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [1:0]            fail_code;
  logic [LW-1:0]         match_idx;
  logic [CW-1:0]         cycles;
  logic [AW-1:0]         err_adr;
  logic [DW-1:0]         err_data;

  int n_pass = 0;
  int n_total = 0;

  store_check_monitor #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .NUM_IGN(NUM_IGN), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ld_we(ld_we), .ld_idx(ld_idx),
    .ld_adr(ld_adr), .ld_data(ld_data), .exp_len(exp_len), .ign_adr(ign_adr),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .match_idx(match_idx), .cycles(cycles), .err_adr(err_adr), .err_data(err_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_we = 1'b1; ld_idx = idx; ld_adr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic go(input logic [LW-1:0] len);
    exp_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".pass"}, 32'(pass), 0);
    chk({tag, ".code"}, 32'(fail_code), 0);
    chk({tag, ".match"}, 32'(match_idx), 0);
    chk({tag, ".cycles"}, 32'(cycles), 0);
    chk({tag, ".err_adr"}, err_adr, 0);
    chk({tag, ".err_data"}, err_data, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single-entry table, ignored store then correct store
    load(0, 32'd100, 32'd7);
    go(1);
    chk("t1.busy_after_start", 32'(busy), 1);
    chk("t1.cycles_after_start", 32'(cycles), 0);
    store(32'd96, 32'd3);
    chk("t1.busy_after_ign", 32'(busy), 1);
    chk("t1.match_after_ign", 32'(match_idx), 0);
    chk("t1.cycles_after_ign", 32'(cycles), 1);
    store(32'd100, 32'd7);
    chk("t1.pass", 32'(pass), 1);
    chk("t1.done", 32'(done), 1);
    chk("t1.busy", 32'(busy), 0);
    chk("t1.code", 32'(fail_code), 0);
    chk("t1.match", 32'(match_idx), 1);
    chk("t1.cycles", 32'(cycles), 2);
    // Store outside RUN is ignored
    store(32'd200, 32'd1);
    chk("t1.post_pass", 32'(pass), 1);
    chk("t1.post_code", 32'(fail_code), 0);
    chk("t1.post_cycles", 32'(cycles), 2);

    // Data mismatch
    go(1);
    store(32'd100, 32'd8);
    chk("t2.done", 32'(done), 1);
    chk("t2.pass", 32'(pass), 0);
    chk("t2.code", 32'(fail_code), 1);
    chk("t2.err_adr", err_adr, 100);
    chk("t2.err_data", err_data, 8);
    chk("t2.match", 32'(match_idx), 0);

    // Unexpected address
    go(1);
    chk("t3.cleared_code", 32'(fail_code), 0);
    chk("t3.cleared_err_adr", err_adr, 0);
    store(32'd104, 32'd7);
    chk("t3.code", 32'(fail_code), 2);
    chk("t3.err_adr", err_adr, 104);
    chk("t3.err_data", err_data, 7);

    // Timeout after 20 RUN edges
    go(1);
    for (int i = 0; i < 19; i++) tick();
    chk("t4.busy_at_19", 32'(busy), 1);
    chk("t4.done_at_19", 32'(done), 0);
    chk("t4.cycles_at_19", 32'(cycles), 19);
    tick();
    chk("t4.done", 32'(done), 1);
    chk("t4.pass", 32'(pass), 0);
    chk("t4.code", 32'(fail_code), 3);
    chk("t4.cycles", 32'(cycles), 20);
    chk("t4.err_adr", err_adr, 0);
    chk("t4.err_data", err_data, 0);
    tick();
    chk("t4.cycles_hold", 32'(cycles), 20);

    // Three ordered stores with ignored stores interleaved
    load(0, 32'h10, 32'd1);
    load(1, 32'h14, 32'd2);
    load(2, 32'h18, 32'd3);
    go(3);
    store(32'd96, 32'd5);
    store(32'h10, 32'd1);
    store(32'd96, 32'd9);
    store(32'h14, 32'd2);
    chk("t5.match_mid", 32'(match_idx), 2);
    chk("t5.busy_mid", 32'(busy), 1);
    store(32'h18, 32'd3);
    chk("t5.pass", 32'(pass), 1);
    chk("t5.match", 32'(match_idx), 3);

    // Out-of-order store to a later table address
    go(3);
    store(32'h14, 32'd2);
    chk("t6.code", 32'(fail_code), 2);
    chk("t6.match", 32'(match_idx), 0);
    chk("t6.err_adr", err_adr, 32'h14);

    // Asynchronous reset two cycles into RUN
    go(3);
    store(32'h10, 32'd1);
    tick();
    chk("t7.match_before", 32'(match_idx), 1);
    chk("t7.cycles_before", 32'(cycles), 2);
    reset = 1'b0;
    #1;
    chk_all_zero("t7.async");
    tick();
    reset = 1'b1;
    tick();

    // Rerun with retained table; table writes during RUN are ignored
    go(3);
    load(1, 32'h14, 32'd99);
    store(32'h10, 32'd1);
    store(32'h14, 32'd2);
    store(32'h18, 32'd3);
    chk("t8.pass", 32'(pass), 1);
    chk("t8.match", 32'(match_idx), 3);
    chk("t8.code", 32'(fail_code), 0);

    // Zero-length run passes one edge after start
    go(0);
    chk("t9.pass", 32'(pass), 1);
    chk("t9.done", 32'(done), 1);
    chk("t9.busy", 32'(busy), 0);
    chk("t9.match", 32'(match_idx), 0);
    chk("t9.cycles", 32'(cycles), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
